// File: rtl/pipe_reg_skid.sv
// Elastic pipeline register: STAGES chained main+skid stages with valid/ready
// handshake, synchronous flush and a programmable reset value for the data path.
module pipe_reg_skid #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           STAGES      = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned           CNT_WIDTH   = $clog2(2 * STAGES + 1)
) (
    input  logic                  PREG_Clk,
    input  logic                  PREG_Reset,
    input  logic                  PREG_Flush,
    input  logic                  PREG_In_Valid,
    input  logic [DATA_WIDTH-1:0] PREG_In_Data,
    output logic                  PREG_In_Ready,
    output logic                  PREG_Out_Valid,
    output logic [DATA_WIDTH-1:0] PREG_Out_Data,
    input  logic                  PREG_Out_Ready,
    output logic [CNT_WIDTH-1:0]  PREG_Count
);

    // Per-stage state gathered at the top so neighbouring stages can see it.
    logic [STAGES-1:0]     main_vld;
    logic [STAGES-1:0]     skid_vld;
    logic [STAGES-1:0]     acc_v;
    logic [STAGES-1:0]     drn_v;
    logic [DATA_WIDTH-1:0] main_dat [STAGES];

    logic                 in_rdy_q, in_rdy_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic                  main_vld_q, main_vld_d;
        logic                  skid_vld_q, skid_vld_d;
        logic [DATA_WIDTH-1:0] main_q, main_d;
        logic [DATA_WIDTH-1:0] skid_q, skid_d;
        logic                  in_vld;
        logic [DATA_WIDTH-1:0] in_dat;
        logic                  out_rdy;
        logic                  acc;
        logic                  drn;

        if (k == 0) begin : g_head
            assign in_vld = PREG_In_Valid;
            assign in_dat = PREG_In_Data;
        end else begin : g_chain
            assign in_vld = main_vld[k-1];
            assign in_dat = main_dat[k-1];
        end

        // Ready toward the upstream stage comes only from our skid flop.
        if (k == STAGES - 1) begin : g_tail
            assign out_rdy = PREG_Out_Ready;
        end else begin : g_mid
            assign out_rdy = ~skid_vld[k+1];
        end

        assign acc = in_vld & ~skid_vld_q;
        assign drn = main_vld_q & out_rdy;

        assign main_vld[k] = main_vld_q;
        assign skid_vld[k] = skid_vld_q;
        assign main_dat[k] = main_q;
        assign acc_v[k]    = acc;
        assign drn_v[k]    = drn;

        // Stage next-state: main fills first, skid catches a word that arrives under stall.
        always_comb begin
            main_d     = main_q;
            skid_d     = skid_q;
            main_vld_d = main_vld_q;
            skid_vld_d = skid_vld_q;
            if (skid_vld_q) begin
                if (drn) begin
                    main_d     = skid_q;
                    skid_vld_d = 1'b0;
                end
            end else if (acc && (!main_vld_q || drn)) begin
                main_d     = in_dat;
                main_vld_d = 1'b1;
            end else if (acc) begin
                skid_d     = in_dat;
                skid_vld_d = 1'b1;
            end else if (drn) begin
                main_vld_d = 1'b0;
            end
        end

        // Stage registers: reset restores data, flush only drops the valid flags.
        always_ff @(posedge PREG_Clk) begin
            if (PREG_Reset) begin
                main_vld_q <= 1'b0;
                skid_vld_q <= 1'b0;
                main_q     <= RESET_VALUE;
                skid_q     <= RESET_VALUE;
            end else if (PREG_Flush) begin
                main_vld_q <= 1'b0;
                skid_vld_q <= 1'b0;
            end else begin
                main_vld_q <= main_vld_d;
                skid_vld_q <= skid_vld_d;
                main_q     <= main_d;
                skid_q     <= skid_d;
            end
        end
    end

    // Occupancy tracks boundary handshakes; In_Ready mirrors the next stage-0 skid state.
    always_comb begin
        cnt_d = cnt_q;
        if (acc_v[0] && !drn_v[STAGES-1]) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!acc_v[0] && drn_v[STAGES-1]) begin
            cnt_d = cnt_q - 1'b1;
        end
        in_rdy_d = ~g_stage[0].skid_vld_d;
    end

    // Boundary registers.
    always_ff @(posedge PREG_Clk) begin
        if (PREG_Reset || PREG_Flush) begin
            cnt_q    <= '0;
            in_rdy_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            in_rdy_q <= in_rdy_d;
        end
    end

    assign PREG_In_Ready  = in_rdy_q;
    assign PREG_Out_Valid = main_vld[STAGES-1];
    assign PREG_Out_Data  = main_dat[STAGES-1];
    assign PREG_Count     = cnt_q;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: four instances (STAGES 1..4) share one stimulus stream;
// a per-instance FIFO model checks order, occupancy, stall stability and latency.
module tb_pipe_reg_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic [3:0]  ir;
    logic [3:0]  ov;
    logic [31:0] od [4];
    logic [3:0]  cnt_a [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned S = g + 1;
        logic [$clog2(2 * S + 1)-1:0] cnt;
        pipe_reg_skid #(
            .DATA_WIDTH (32),
            .STAGES     (S),
            .RESET_VALUE(32'hDEADBEEF)
        ) u_dut (
            .PREG_Clk      (clk),
            .PREG_Reset    (rst),
            .PREG_Flush    (flush),
            .PREG_In_Valid (in_valid),
            .PREG_In_Data  (in_data),
            .PREG_In_Ready (ir[g]),
            .PREG_Out_Valid(ov[g]),
            .PREG_Out_Data (od[g]),
            .PREG_Out_Ready(out_ready),
            .PREG_Count    (cnt)
        );
        assign cnt_a[g] = 4'(cnt);
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d (STAGES=%0d): got %h, expected %h",
                     name, d, d + 1, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    // Reference model: a FIFO per instance plus a pure delay line for free-flow latency.
    logic [31:0] mem [4][16];
    int          head [4];
    int          size [4];
    logic        sr_v [4][4];
    logic [31:0] sr_d [4][4];
    logic        prev_stall [4];
    logic [31:0] prev_data [4];
    logic        just_clr [4];
    bit          model_on = 1'b0;
    bit          prev_rst = 1'b0;
    bit          ff_mode = 1'b0;

    initial begin
        bit acc, drn;
        for (int d = 0; d < 4; d++) begin
            head[d] = 0;
            size[d] = 0;
            prev_stall[d] = 1'b0;
            just_clr[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (model_on) begin
                    check("count", d, 32'(cnt_a[d]), size[d]);
                    if (ov[d] === 1'b1) begin
                        check("valid_implies_stored", d, 32'(size[d] > 0), 1);
                        if (size[d] > 0) check("out_data_order", d, od[d], mem[d][head[d]]);
                    end
                    if (just_clr[d]) begin
                        check("clear_valid", d, 32'(ov[d]), 0);
                        check("clear_ready", d, 32'(ir[d]), 1);
                    end
                    if (size[d] == 2 * (d + 1)) check("ready_at_capacity", d, 32'(ir[d]), 0);
                    if (ir[d] !== 1'b1) check("ready_low_needs_two", d, 32'(size[d] >= 2), 1);
                    if (prev_stall[d]) begin
                        check("stall_valid", d, 32'(ov[d]), 1);
                        check("stall_data", d, od[d], prev_data[d]);
                    end else if (ov[d] !== 1'b1 && !prev_rst) begin
                        check("idle_hold", d, od[d], prev_data[d]);
                    end
                    if (prev_rst) check("reset_data", d, od[d], 32'hDEADBEEF);
                    if (ff_mode) begin
                        check("ff_valid", d, 32'(ov[d]), 32'(sr_v[d][d]));
                        if (sr_v[d][d]) check("ff_data", d, od[d], sr_d[d][d]);
                        check("ff_ready", d, 32'(ir[d]), 1);
                    end
                end
                if (rst === 1'b1) begin
                    size[d] = 0;
                    head[d] = 0;
                    just_clr[d] = 1'b1;
                    prev_stall[d] = 1'b0;
                    for (int j = 0; j < 4; j++) sr_v[d][j] = 1'b0;
                end else if (model_on) begin
                    acc = (in_valid === 1'b1) && (ir[d] === 1'b1);
                    drn = (ov[d] === 1'b1) && (out_ready === 1'b1);
                    if (flush === 1'b1) begin
                        size[d] = 0;
                        just_clr[d] = 1'b1;
                        prev_stall[d] = 1'b0;
                        for (int j = 0; j < 4; j++) sr_v[d][j] = 1'b0;
                    end else begin
                        just_clr[d] = 1'b0;
                        if (drn && size[d] > 0) begin
                            head[d] = (head[d] + 1) % 16;
                            size[d]--;
                        end
                        if (acc) begin
                            mem[d][(head[d] + size[d]) % 16] = in_data;
                            size[d]++;
                        end
                        for (int j = 3; j > 0; j--) begin
                            sr_v[d][j] = sr_v[d][j-1];
                            sr_d[d][j] = sr_d[d][j-1];
                        end
                        sr_v[d][0] = acc;
                        sr_d[d][0] = in_data;
                        prev_stall[d] = (ov[d] === 1'b1) && (out_ready !== 1'b1);
                    end
                end
                prev_data[d] = od[d];
            end
            if (rst === 1'b1) model_on = 1'b1;
            prev_rst = (rst === 1'b1);
        end
    end

    // Hand-computed expectations for the directed sequences.
    int t2_ov  [6] = '{0, 0, 1, 1, 1, 0};
    int t2_dat [6] = '{0, 0, 1, 2, 3, 0};
    int t2_cnt [6] = '{0, 1, 2, 2, 1, 0};
    int t3_ov  [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    int t3_dat [8] = '{32'hDEADBEEF, 32'hA, 32'hA, 32'hA, 32'hA, 32'hB, 32'hC, 32'hC};
    int t3_cnt [8] = '{0, 1, 2, 2, 2, 1, 1, 0};
    int t3_ir  [8] = '{1, 1, 0, 0, 0, 1, 1, 1};

    initial begin
        int pv, pr;
        cyc();

        // Reset values
        do_reset();
        @(negedge clk);
        check("t1_out_data", 1, od[1], 32'hDEADBEEF);
        check("t1_out_valid", 1, 32'(ov[1]), 0);
        check("t1_in_ready", 1, 32'(ir[1]), 1);
        check("t1_count", 1, 32'(cnt_a[1]), 0);
        cyc();

        // Stream 1,2,3 through two stages with Out_Ready held high
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 3);
            in_data  = 32'(c + 1);
            @(negedge clk);
            check("t2_valid", 1, 32'(ov[1]), t2_ov[c]);
            if (t2_ov[c] == 1) check("t2_data", 1, od[1], t2_dat[c]);
            check("t2_count", 1, 32'(cnt_a[1]), t2_cnt[c]);
            cyc();
        end

        // Single stage: fill main+skid, hold C, then release
        out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            in_valid  = (c < 6);
            in_data   = (c == 0) ? 32'hA : (c == 1) ? 32'hB : 32'hC;
            out_ready = (c >= 4);
            @(negedge clk);
            check("t3_valid", 0, 32'(ov[0]), t3_ov[c]);
            check("t3_data", 0, od[0], t3_dat[c]);
            check("t3_count", 0, 32'(cnt_a[0]), t3_cnt[c]);
            check("t3_ready", 0, 32'(ir[0]), t3_ir[c]);
            cyc();
        end

        // Fill two stages, flush with a word offered; it must never come out
        out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            in_valid  = (c < 5);
            in_data   = (c < 4) ? 32'(c + 1) : 32'd9;
            flush     = (c == 4);
            out_ready = (c >= 5);
            @(negedge clk);
            if (c == 3) begin
                check("t4_count_pre", 1, 32'(cnt_a[1]), 3);
                check("t4_ready_pre", 1, 32'(ir[1]), 1);
            end
            if (c == 4) begin
                check("t4_count_full", 1, 32'(cnt_a[1]), 4);
                check("t4_ready_full", 1, 32'(ir[1]), 0);
                check("t4_data_full", 1, od[1], 32'd1);
            end
            if (c >= 5) begin
                check("t4_valid_post", 1, 32'(ov[1]), 0);
                check("t4_count_post", 1, 32'(cnt_a[1]), 0);
                check("t4_ready_post", 1, 32'(ir[1]), 1);
            end
            cyc();
        end

        // Reset mid-stream with three words stored
        out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            in_valid = (c < 4);
            in_data  = 32'h11 * 32'(c + 1);
            rst      = (c == 3);
            @(negedge clk);
            if (c == 3) check("t6_count_pre", 1, 32'(cnt_a[1]), 3);
            if (c == 4) begin
                for (int d = 0; d < 4; d++) begin
                    check("t6_valid", d, 32'(ov[d]), 0);
                    check("t6_ready", d, 32'(ir[d]), 1);
                    check("t6_count", d, 32'(cnt_a[d]), 0);
                    check("t6_data", d, od[d], 32'hDEADBEEF);
                end
            end
            cyc();
        end

        // Free flow: exact STAGES-cycle latency and full throughput
        do_reset();
        out_ready = 1'b1;
        ff_mode   = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            in_data  = $urandom;
            cyc();
        end
        ff_mode = 1'b0;

        // Random back-pressure with occasional flushes
        for (int b = 0; b < 8; b++) begin
            pv = $urandom_range(20, 95);
            pr = $urandom_range(10, 95);
            for (int c = 0; c < 1000; c++) begin
                in_valid  = ($urandom_range(0, 99) < pv);
                out_ready = ($urandom_range(0, 99) < pr);
                flush     = ($urandom_range(0, 199) == 0);
                in_data   = $urandom;
                cyc();
            end
        end

        // Drain: everything stored must leave
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) cyc();
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check("drain_empty", d, 32'(cnt_a[d]), 0);
            check("drain_valid", d, 32'(ov[d]), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
